hi_adc_wb_regs: RTL and testbench
=================================

HI_ADC_WB_REGS -- requirements
Module: hi_adc_wb_regs

Interface
REQ-001 SHALL have parameter N_CH, default 8, number of ADC channels implemented (legal 1..8).
REQ-002 SHALL have parameter DW, default 24, ADC sample width (legal 8..32); samples are sign-extended to 32 bits on readback.
REQ-003 SHALL have ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  Wishbone request
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address; adr[1:0] ignored
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  ack
- wbs_dat_o  out  32  read data
- core_status  in  8  status passthrough
- adc_smp_valid  in  1  sample strobe
- adc_smp_ch  in  3  sample channel
- adc_smp_data  in  DW  sample value
- ctrl_enable  out  1  CTRL.ENABLE
- ctrl_start  out  1  one-cycle start pulse
- snap_busy  out  1  snapshot in progress
- irq_o  out  1  registered interrupt

Function
REQ-004 SHALL accept a request when cyc&stb&~ack; ack SHALL assert exactly one cycle after accept for one cycle; back-to-back accepts therefore occur at most every second cycle.
REQ-005 SHALL latch read data into wbs_dat_o on accept; unmapped reads return 0; unmapped writes are ignored; writes honour wbs_sel_i per byte.
REQ-006 SHALL decode: 0x000 ID RO 0x4849_4348; 0x004 VERSION RO 0x0000_0002; 0x100 CTRL (bit0 ENABLE RW, bit1 START W1P, reads 0); 0x104 IRQ_EN [1:0] RW; 0x108 STATUS RO {24'h0,core_status}; 0x10C IRQ_PEND [1:0] W1C; 0x200 ADC_CFG ([3:0] NUM_CH RW, [8] BUSY RO); 0x204 ADC_CMD bit0 SNAPSHOT W1P; 0x208 SNAP_CNT RO; 0x210+4*k RAW_CHk for k<N_CH, RAW_CHk for k>=N_CH reads 0.
REQ-007 SHALL clamp NUM_CH writes greater than N_CH to N_CH.
REQ-008 SHALL update live register k on the cycle after adc_smp_valid with adc_smp_ch=k; samples with ch>=N_CH SHALL be dropped.
REQ-009 Snapshot FSM states IDLE, COPY, DONE: IDLE->COPY on SNAPSHOT write when ENABLE=1 and NUM_CH>0; COPY copies live[idx] to RAW[idx] one channel per cycle, idx 0..NUM_CH-1; after last copy ->DONE; DONE->IDLE next cycle setting IRQ_PEND[0] and incrementing SNAP_CNT.
REQ-010 SNAPSHOT with NUM_CH=0 and ENABLE=1 SHALL go IDLE->DONE directly (no copies, pending and count still updated).
REQ-011 SNAPSHOT while ENABLE=0 or while not IDLE SHALL be ignored.
REQ-012 COPY SHALL copy the live value registered before any same-cycle sample update.
REQ-013 NUM_CH writes during COPY SHALL not affect the running snapshot (count latched at start).
REQ-014 snap_busy SHALL be 1 in COPY and DONE; ADC_CFG.BUSY mirrors it.
REQ-015 SNAP_CNT SHALL wrap 0xFFFF_FFFF->0.
REQ-016 IRQ_PEND set and W1C clear in the same cycle SHALL leave the bit set.
REQ-017 irq_o SHALL be registered |(IRQ_PEND & IRQ_EN), one cycle after pending/enable change.
REQ-018 Writing ENABLE=0 during COPY SHALL not abort the snapshot.

Reset
REQ-019 On wb_rst_i, all outputs, CTRL, IRQ_EN, IRQ_PEND, NUM_CH, SNAP_CNT, live and RAW registers SHALL clear to 0 and FSM to IDLE, including mid-snapshot; reset SHALL suppress ack for an in-flight request.

Configuration
REQ-020 With HI_ADC_OVR_EN defined, each channel SHALL keep a fresh flag set on sample, cleared when copied; a sample to a fresh channel SHALL set IRQ_PEND[1] (overrun); a sample and a copy of the same channel in the same cycle SHALL leave the flag set with no overrun.
REQ-021 Without HI_ADC_OVR_EN, IRQ_PEND[1] and IRQ_EN[1] SHALL read 0 and no fresh-flag logic is generated.

Verification
REQ-022 Reset, read 0x000 -> 0x4849_4348; read 0x004 -> 0x0000_0002; ack exactly one cycle after accept.
REQ-023 ENABLE=1, NUM_CH=4, samples ch0..3 = 0x800000,1,2,3 (DW=24), SNAPSHOT -> snap_busy 5 cycles, RAW_CH0=0xFF80_0000, RAW_CH3=3, SNAP_CNT=1, IRQ_PEND=1.
REQ-024 Write NUM_CH=15 with N_CH=8 -> reads 8; read RAW at 0x230 -> 0.
REQ-025 IRQ_EN=1, snapshot done -> irq_o=1; W1C 0x10C=1 in same cycle as second snapshot DONE -> pending remains 1.
REQ-026 HI_ADC_OVR_EN: two samples to ch2 without snapshot -> IRQ_PEND=0b10; without macro -> 0.
REQ-027 Assert reset during COPY -> snap_busy=0, RAW all 0, SNAP_CNT=0 next cycle.

Source files
------------

// File: rtl/hi_adc_wb_regs.sv
// Wishbone register block for a multi-channel ADC with a live->RAW snapshot engine.
// Define HI_ADC_OVR_EN to build per-channel fresh flags and the overrun interrupt (IRQ_PEND[1]).
module hi_adc_wb_regs #(
  parameter int N_CH = 8,
  parameter int DW   = 24
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  input  logic [7:0]    core_status,
  input  logic          adc_smp_valid,
  input  logic [2:0]    adc_smp_ch,
  input  logic [DW-1:0] adc_smp_data,
  output logic          ctrl_enable,
  output logic          ctrl_start,
  output logic          snap_busy,
  output logic          irq_o
);
  typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

  localparam logic [3:0] MAX_CH = 4'(N_CH);

  state_t        state_reg;
  logic          ack_reg;
  logic [31:0]   dat_reg;
  logic          enable_reg;
  logic          start_reg;
  logic          irq_reg;
  logic [1:0]    irq_en_reg;
  logic [1:0]    irq_pend_reg;
  logic [1:0]    pend_next;
  logic [3:0]    num_ch_reg;
  logic [3:0]    copy_cnt_reg;
  logic [2:0]    idx_reg;
  logic [31:0]   snap_cnt_reg;
  logic [DW-1:0] live_reg [N_CH];
  logic [DW-1:0] raw_reg  [N_CH];
  logic [31:0]   raw_ext  [8];
  logic [N_CH-1:0] smp_hit;
  logic [N_CH-1:0] copy_sel;

  logic        accept;
  logic        wr0;
  logic [29:0] word;
  logic [29:0] raw_rel;
  logic        hit_ctrl, hit_irq_en, hit_pend, hit_cfg, hit_cmd;
  logic        snap_req;
  logic        done_now;
  logic        overrun;
  logic [1:0]  en_mask;
  logic [1:0]  pend_clr;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign accept     = wbs_cyc_i & wbs_stb_i & ~ack_reg;
  assign wr0        = accept & wbs_we_i & wbs_sel_i[0];
  assign word       = wbs_adr_i[31:2];
  assign raw_rel    = word - 30'h84;
  assign hit_ctrl   = (word == 30'h40);
  assign hit_irq_en = (word == 30'h41);
  assign hit_pend   = (word == 30'h43);
  assign hit_cfg    = (word == 30'h80);
  assign hit_cmd    = (word == 30'h81);
  assign snap_req   = wr0 & hit_cmd & wbs_dat_i[0] & enable_reg & (state_reg == IDLE);
  assign done_now   = (state_reg == DONE);
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:4], wbs_sel_i[3:1]};

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign smp_hit[gi]  = adc_smp_valid & (adc_smp_ch == 3'(gi));
      assign copy_sel[gi] = (state_reg == COPY) & (idx_reg == 3'(gi));

      // Nonblocking copy picks up the live value from before any same-cycle sample.
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          live_reg[gi] <= '0;
          raw_reg[gi]  <= '0;
        end else begin
          if (smp_hit[gi])
            live_reg[gi] <= adc_smp_data;
          if (copy_sel[gi])
            raw_reg[gi] <= live_reg[gi];
        end
      end
    end

    for (gi = 0; gi < 8; gi++) begin : g_raw_rd
      if (gi < N_CH) begin : g_impl
        assign raw_ext[gi] = 32'($signed(raw_reg[gi]));
      end else begin : g_zero
        assign raw_ext[gi] = 32'h0;
      end
    end
  endgenerate

`ifdef HI_ADC_OVR_EN
  logic [N_CH-1:0] fresh_reg;

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_fresh
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
          fresh_reg[gi] <= 1'b0;
        else if (smp_hit[gi])
          fresh_reg[gi] <= 1'b1;
        else if (copy_sel[gi])
          fresh_reg[gi] <= 1'b0;
      end
    end
  endgenerate

  assign overrun = |(smp_hit & fresh_reg & ~copy_sel);
  assign en_mask = 2'b11;
`else
  assign overrun = 1'b0;
  assign en_mask = 2'b01;
`endif

  // Set wins over a same-cycle write-one-to-clear.
  assign pend_clr  = (wr0 & hit_pend) ? wbs_dat_i[1:0] : 2'b00;
  assign pend_next = ((irq_pend_reg & ~pend_clr) | {overrun, done_now}) & en_mask;

  always_comb begin
    rd_data = 32'h0;
    case (word)
      30'h00:  rd_data = 32'h4849_4348;
      30'h01:  rd_data = 32'h0000_0002;
      30'h41:  rd_data = {30'h0, irq_en_reg};
      30'h42:  rd_data = {24'h0, core_status};
      30'h43:  rd_data = {30'h0, irq_pend_reg};
      30'h80:  rd_data = {23'h0, snap_busy, 4'h0, num_ch_reg};
      30'h82:  rd_data = snap_cnt_reg;
      default: if (raw_rel < 30'd8) rd_data = raw_ext[raw_rel[2:0]];
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg      <= 1'b0;
      dat_reg      <= 32'h0;
      enable_reg   <= 1'b0;
      start_reg    <= 1'b0;
      irq_en_reg   <= 2'b00;
      irq_pend_reg <= 2'b00;
      num_ch_reg   <= 4'h0;
      irq_reg      <= 1'b0;
    end else begin
      ack_reg      <= accept;
      start_reg    <= wr0 & hit_ctrl & wbs_dat_i[1];
      irq_pend_reg <= pend_next;
      irq_reg      <= |(irq_pend_reg & irq_en_reg);
      if (accept)
        dat_reg <= wbs_we_i ? 32'h0 : rd_data;
      if (wr0 & hit_ctrl)
        enable_reg <= wbs_dat_i[0];
      if (wr0 & hit_irq_en)
        irq_en_reg <= wbs_dat_i[1:0] & en_mask;
      if (wr0 & hit_cfg)
        num_ch_reg <= (wbs_dat_i[3:0] > MAX_CH) ? MAX_CH : wbs_dat_i[3:0];
    end
  end

  // Channel count is latched at start so NUM_CH/ENABLE writes cannot disturb a running copy.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= IDLE;
      idx_reg      <= 3'h0;
      copy_cnt_reg <= 4'h0;
      snap_cnt_reg <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (snap_req) begin
            copy_cnt_reg <= num_ch_reg;
            idx_reg      <= 3'h0;
            state_reg    <= (num_ch_reg == 4'h0) ? DONE : COPY;
          end
        end
        COPY: begin
          idx_reg <= idx_reg + 3'h1;
          if (({1'b0, idx_reg} + 4'h1) == copy_cnt_reg)
            state_reg <= DONE;
        end
        DONE: begin
          state_reg    <= IDLE;
          snap_cnt_reg <= snap_cnt_reg + 32'h1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wbs_ack_o   = ack_reg;
  assign wbs_dat_o   = dat_reg;
  assign ctrl_enable = enable_reg;
  assign ctrl_start  = start_reg;
  assign snap_busy   = (state_reg != IDLE);
  assign irq_o       = irq_reg;
endmodule

// File: tb/tb_hi_adc_wb_regs.sv
// Randomized bench for hi_adc_wb_regs against a transaction-level register/ADC model.
module tb_hi_adc_wb_regs;
  localparam int N_CH = 8;
  localparam int DW   = 24;
`ifdef HI_ADC_OVR_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat, rdat;
  logic          ack;
  logic [7:0]    status;
  logic          smp_valid;
  logic [2:0]    smp_ch;
  logic [DW-1:0] smp_data;
  logic          enable_o, start_o, busy_o, irq;

  always #5 clk = ~clk;

  hi_adc_wb_regs #(.N_CH(N_CH), .DW(DW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .core_status(status),
    .adc_smp_valid(smp_valid), .adc_smp_ch(smp_ch), .adc_smp_data(smp_data),
    .ctrl_enable(enable_o), .ctrl_start(start_o), .snap_busy(busy_o), .irq_o(irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_live [8];
  logic [31:0] m_raw  [8];
  bit          m_fresh [8];
  bit          m_enable;
  logic [1:0]  m_irq_en, m_pend;
  logic [3:0]  m_num_ch;
  logic [31:0] m_cnt;
  logic        last_busy, last_start;

  localparam logic [31:0] DMASK = (DW == 32) ? 32'hFFFF_FFFF : ((32'h1 << DW) - 32'h1);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) begin
      m_live[k] = 0; m_raw[k] = 0; m_fresh[k] = 0;
    end
    m_enable = 0; m_irq_en = 0; m_pend = 0; m_num_ch = 0; m_cnt = 0;
  endfunction

  function automatic logic [31:0] sext(input logic [31:0] v);
    if (v[DW-1]) return v | ~DMASK;
    return v;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] w;
    int k;
    w = {a[31:2], 2'b00};
    case (w)
      32'h000: return 32'h4849_4348;
      32'h004: return 32'h0000_0002;
      32'h104: return {30'b0, m_irq_en};
      32'h108: return {24'b0, status};
      32'h10C: return {30'b0, m_pend};
      32'h200: return {28'b0, m_num_ch};
      32'h208: return m_cnt;
      default: begin
        if (w >= 32'h210 && w < 32'h230) begin
          k = int'((w - 32'h210) >> 2);
          if (k < N_CH) return sext(m_raw[k]);
        end
        return 32'h0;
      end
    endcase
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (!s[0]) return;
    case (w)
      32'h100: m_enable = d[0];
      32'h104: m_irq_en = d[1:0] & (OVR ? 2'b11 : 2'b01);
      32'h10C: m_pend = m_pend & ~d[1:0];
      32'h200: m_num_ch = (d[3:0] > 4'(N_CH)) ? 4'(N_CH) : d[3:0];
      default: ;
    endcase
  endfunction

  function automatic void model_snap(input int cnt);
    for (int k = 0; k < cnt; k++) begin
      m_raw[k] = m_live[k];
      m_fresh[k] = 0;
    end
    m_pend[0] = 1'b1;
    m_cnt = m_cnt + 1;
  endfunction

  task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
    int n;
    n = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    while (n < 8) begin
      @(posedge clk); #1;
      n++;
      if (ack) break;
    end
    check_val("ack_lat", 32'(n), 32'd1);
    r = rdat;
    last_busy = busy_o;
    last_start = start_o;
    cyc = 0; stb = 0; we = 0;
    @(posedge clk); #1;
    check_val("ack_len", {31'b0, ack}, 32'd0);
    $display("wb %s adr=%08h sel=%h wdat=%08h rdat=%08h", w ? "wr" : "rd", a, s, d, r);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_cycle(a, 1'b1, d, s, r);
    model_write(a, d, s);
    if ({a[31:2], 2'b00} == 32'h100) begin
      check_val("ctrl_start", {31'b0, last_start}, {31'b0, s[0] & d[1]});
      check_val("ctrl_enable", {31'b0, enable_o}, {31'b0, m_enable});
    end
  endtask

  task automatic wb_read(input logic [31:0] a, input string tag, output logic [31:0] r);
    logic [31:0] e;
    e = exp_read(a);
    wb_cycle(a, 1'b0, 32'h0, 4'hF, r);
    check_val(tag, r, e);
  endtask

  task automatic sample(input logic [2:0] ch, input logic [31:0] d);
    @(negedge clk);
    smp_valid = 1; smp_ch = ch; smp_data = d[DW-1:0];
    @(negedge clk);
    smp_valid = 0;
    if (int'(ch) < N_CH) begin
      if (OVR && m_fresh[ch]) m_pend[1] = 1'b1;
      m_fresh[ch] = 1'b1;
      m_live[ch] = d & DMASK;
    end
    $display("smp ch=%0d data=%06h", ch, d & DMASK);
  endtask

  task automatic wait_idle(output int n);
    n = int'(last_busy);
    while (busy_o && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic snapshot();
    bit started;
    int cnt, n;
    logic [31:0] r;
    started = m_enable;
    cnt = int'(m_num_ch);
    wb_cycle(32'h204, 1'b1, 32'h1, 4'hF, r);
    wait_idle(n);
    check_val("busy_cycles", 32'(n), started ? 32'(cnt + 1) : 32'd0);
    if (started) model_snap(cnt);
  endtask

  task automatic check_irq();
    @(posedge clk); #1;
    check_val("irq", {31'b0, irq}, {31'b0, |(m_pend & m_irq_en)});
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  logic [31:0] rd_addrs [16] = '{32'h000, 32'h004, 32'h100, 32'h104, 32'h108, 32'h10C,
                                 32'h200, 32'h204, 32'h208, 32'h210, 32'h214, 32'h21C,
                                 32'h228, 32'h22C, 32'h230, 32'h00C};
  logic [31:0] wr_addrs [8]  = '{32'h100, 32'h104, 32'h10C, 32'h200, 32'h208, 32'h000,
                                 32'h300, 32'h100};

  initial begin
    logic [31:0] r;
    int n, op;
    rst = 1; cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    smp_valid = 0; smp_ch = 0; smp_data = 0; status = 8'hA5;
    last_busy = 0; last_start = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ack", {31'b0, ack}, 0);
    check_val("rst_dat", rdat, 0);
    check_val("rst_busy", {31'b0, busy_o}, 0);
    check_val("rst_irq", {31'b0, irq}, 0);
    check_val("rst_enable", {31'b0, enable_o}, 0);
    check_val("rst_start", {31'b0, start_o}, 0);
    @(negedge clk);
    rst = 0;

    // Identification
    wb_read(32'h000, "id", r);
    wb_read(32'h004, "version", r);
    wb_read(32'h108, "status", r);

    // Basic snapshot with sign extension
    wb_write(32'h100, 32'h1, 4'hF);
    wb_write(32'h200, 32'h4, 4'hF);
    sample(3'd0, 32'h800000);
    sample(3'd1, 32'h1);
    sample(3'd2, 32'h2);
    sample(3'd3, 32'h3);
    snapshot();
    wb_read(32'h210, "raw0", r);
    check_val("raw0_sext", r, 32'hFF80_0000);
    wb_read(32'h21C, "raw3", r);
    wb_read(32'h208, "snap_cnt", r);
    wb_read(32'h10C, "pend", r);

    // NUM_CH clamp and out-of-range RAW
    wb_write(32'h200, 32'hF, 4'hF);
    wb_read(32'h200, "num_ch_clamp", r);
    wb_read(32'h230, "raw_oob", r);

    // Interrupt, then W1C racing the DONE state of a one-channel snapshot
    wb_write(32'h104, 32'h3, 4'hF);
    check_irq();
    wb_write(32'h200, 32'h1, 4'hF);
    wb_cycle(32'h204, 1'b1, 32'h1, 4'hF, r);
    wb_write(32'h10C, 32'h1, 4'hF);
    wait_idle(n);
    model_snap(1);
    wb_read(32'h10C, "pend_set_wins", r);
    check_irq();

    // Snapshot ignored while disabled
    wb_write(32'h100, 32'h0, 4'hF);
    snapshot();
    wb_read(32'h208, "cnt_disabled", r);

    // NUM_CH / ENABLE / SNAPSHOT writes during COPY do not disturb it
    wb_write(32'h100, 32'h1, 4'hF);
    wb_write(32'h200, 32'h8, 4'hF);
    for (int k = 0; k < N_CH; k++) sample(3'(k), $urandom);
    wb_cycle(32'h204, 1'b1, 32'h1, 4'hF, r);
    wb_write(32'h200, 32'h2, 4'hF);
    wb_write(32'h100, 32'h0, 4'hF);
    wb_cycle(32'h204, 1'b1, 32'h1, 4'hF, r);
    wait_idle(n);
    model_snap(8);
    for (int k = 0; k < N_CH; k++) wb_read(32'h210 + 32'(4 * k), "raw_latched", r);
    wb_read(32'h208, "cnt_latched", r);

    // Overrun: two samples to ch2
    apply_reset();
    sample(3'd2, 32'h11);
    sample(3'd2, 32'h22);
    wb_read(32'h10C, "ovr_pend", r);

    // Reset mid-COPY with a request in flight
    wb_write(32'h100, 32'h1, 4'hF);
    wb_write(32'h200, 32'h8, 4'hF);
    for (int k = 0; k < N_CH; k++) sample(3'(k), $urandom | 32'h1);
    snapshot();
    wb_cycle(32'h204, 1'b1, 32'h1, 4'hF, r);
    @(negedge clk);
    rst = 1; cyc = 1; stb = 1; adr = 32'h0;
    @(posedge clk); #1;
    check_val("rst_copy_busy", {31'b0, busy_o}, 0);
    check_val("rst_inflight_ack", {31'b0, ack}, 0);
    @(negedge clk);
    rst = 0; cyc = 0; stb = 0;
    model_reset();
    for (int k = 0; k < N_CH; k++) wb_read(32'h210 + 32'(4 * k), "raw_after_rst", r);
    wb_read(32'h208, "cnt_after_rst", r);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 2) begin
        sample(3'($urandom_range(0, 7)), $urandom);
      end else if (op <= 5) begin
        wb_write(wr_addrs[$urandom_range(0, 7)], $urandom,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
      end else if (op <= 8) begin
        if ($urandom_range(0, 7) == 0) status = 8'($urandom);
        wb_read(rd_addrs[$urandom_range(0, 15)] | 32'($urandom_range(0, 3)), "rand_rd", r);
      end else begin
        snapshot();
      end
      check_irq();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
